// File: rtl/clock_control_pkg.sv
// Shared configuration for the clock-control slice: default timing
// constants, divisor limits, key indices and the repeat FSM state type.
`ifndef CONFIG_AND_CONSTANTS
`define CONFIG_AND_CONSTANTS

package clock_control_pkg;

    // 100 MHz cycle counts: 10 ms debounce, 500 ms hold, 100 ms repeat
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int REPEAT_DELAY_DEFAULT    = 50000000;
    localparam int REPEAT_PERIOD_DEFAULT   = 10000000;

    localparam logic [4:0] DIVISOR_RESET_DEFAULT = 5'd25;
    localparam logic [4:0] DIVISOR_MIN           = 5'd1;
    localparam logic [4:0] DIVISOR_MAX           = 5'd31;

    // Positions of the keys in the debounced-level vector
    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_MODE = 2;

    typedef enum logic [1:0] {
        KEY_RELEASED  = 2'd0,
        KEY_HOLD_WAIT = 2'd1,
        KEY_REPEATING = 2'd2
    } repeat_state_t;

    // Saturating divisor step; simultaneous up and down cancel out.
    function automatic logic [4:0] next_divisor(
        input logic [4:0] divisor,
        input logic       step_up,
        input logic       step_down
    );
        logic [4:0] result;
        result = divisor;
        if (step_up && !step_down && (divisor < DIVISOR_MAX)) begin
            result = divisor + 5'd1;
        end else if (step_down && !step_up && (divisor > DIVISOR_MIN)) begin
            result = divisor - 5'd1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/key_debouncer.sv
// Two-flop synchronizer followed by a counting debouncer. The clean level
// flips only after DEBOUNCE_CYCLES consecutive synchronized samples that
// disagree with it; a single agreeing sample restarts the count.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock_100mhz,
    input  logic reset,
    input  logic key_raw,
    output logic key_clean
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level
    always_comb begin
        clean_d = clean_q;
        count_d = '0;
        if (sync2_q != clean_q) begin
            if (count_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Register the debounced level and the run counter
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            clean_q <= 1'b0;
            count_q <= '0;
        end else begin
            clean_q <= clean_d;
            count_q <= count_d;
        end
    end

    assign key_clean = clean_q;

endmodule

// File: rtl/clock_control.sv
// Board-key front end for the clock divider: debounces up/down/mode keys,
// runs hold-to-repeat FSMs for up and down, and owns the divisor and
// slow-mode registers plus the delayed settings_changed pulse.
//
// state         | meaning
// KEY_RELEASED  | key up, waiting for a clean rise
// KEY_HOLD_WAIT | first step issued, timing the hold before auto-repeat
// KEY_REPEATING | auto-repeat active, one step per repeat period
module clock_control
    import clock_control_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int         REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int         REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [4:0] DIVISOR_RESET   = DIVISOR_RESET_DEFAULT
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_mode,
    output logic [4:0] clock_divisor,
    output logic       slow_mode,
    output logic       settings_changed
);

    // Timers count down from (interval - 1); sized for the longer interval
    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
    localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

    logic [2:0]         key_clean;
    logic [1:0]         step;

    repeat_state_t      state_q [2];
    repeat_state_t      state_d [2];
    logic [TIMER_W-1:0] timer_q [2];
    logic [TIMER_W-1:0] timer_d [2];

    logic [4:0]         divisor_q;
    logic [4:0]         divisor_d;
    logic               slow_mode_q;
    logic               slow_mode_d;
    logic               mode_prev_q;
    logic               mode_prev_d;
    logic               change_pending_q;
    logic               change_pending_d;
    logic               settings_changed_q;
    logic               settings_changed_d;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .key_raw      (key_up),
        .key_clean    (key_clean[KEY_UP])
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .key_raw      (key_down),
        .key_clean    (key_clean[KEY_DOWN])
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .key_raw      (key_mode),
        .key_clean    (key_clean[KEY_MODE])
    );

    // Hold-to-repeat FSMs for up and down; step is a same-cycle decode so
    // the divisor moves on the edge right after the clean rise
    always_comb begin
        step = '0;
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            timer_d[k] = timer_q[k];
            case (state_q[k])
                KEY_RELEASED: begin
                    if (key_clean[k]) begin
                        step[k]    = 1'b1;
                        state_d[k] = KEY_HOLD_WAIT;
                        timer_d[k] = DELAY_LOAD;
                    end
                end
                KEY_HOLD_WAIT, KEY_REPEATING: begin
                    if (!key_clean[k]) begin
                        state_d[k] = KEY_RELEASED;
                        timer_d[k] = '0;
                    end else if (timer_q[k] == '0) begin
                        step[k]    = 1'b1;
                        state_d[k] = KEY_REPEATING;
                        timer_d[k] = PERIOD_LOAD;
                    end else begin
                        timer_d[k] = timer_q[k] - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d[k] = KEY_RELEASED;
                    timer_d[k] = '0;
                end
            endcase
        end
    end

    // Apply steps and mode toggles; the change pulse trails the update by one cycle
    always_comb begin
        divisor_d          = next_divisor(divisor_q, step[KEY_UP], step[KEY_DOWN]);
        slow_mode_d        = slow_mode_q ^ (key_clean[KEY_MODE] & ~mode_prev_q);
        mode_prev_d        = key_clean[KEY_MODE];
        change_pending_d   = (divisor_d != divisor_q) || (slow_mode_d != slow_mode_q);
        settings_changed_d = change_pending_q;
    end

    // State, timer and output registers
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= KEY_RELEASED;
                timer_q[k] <= '0;
            end
            divisor_q          <= DIVISOR_RESET;
            slow_mode_q        <= 1'b0;
            mode_prev_q        <= 1'b0;
            change_pending_q   <= 1'b0;
            settings_changed_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                timer_q[k] <= timer_d[k];
            end
            divisor_q          <= divisor_d;
            slow_mode_q        <= slow_mode_d;
            mode_prev_q        <= mode_prev_d;
            change_pending_q   <= change_pending_d;
            settings_changed_q <= settings_changed_d;
        end
    end

    assign clock_divisor    = divisor_q;
    assign slow_mode        = slow_mode_q;
    assign settings_changed = settings_changed_q;

endmodule

// File: tb/tb_clock_control.sv
// Testbench for clock_control with short timing constants. A behavioural
// model (sample window for debounce, press age for repeat) runs in lockstep
// and is compared every cycle; hand sequences pin the exact cycle behaviour.
module tb_clock_control;

    localparam int DEB    = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 5;
    localparam int DRST   = 25;
    localparam int HIST_DEPTH = DEB + 2;

    logic       clock_100mhz;
    logic       reset;
    logic       key_up;
    logic       key_down;
    logic       key_mode;
    logic [4:0] clock_divisor;
    logic       slow_mode;
    logic       settings_changed;

    int vectors;
    int miscompares;
    int pulse_count;

    // model state
    bit [2:0] m_hist [HIST_DEPTH];
    bit [2:0] m_clean;
    int       m_age [2];
    int       m_div;
    bit       m_mode;
    bit       m_mode_rise;
    bit       m_pend;
    bit       m_chg;

    typedef struct {
        bit up;
        bit down;
        bit mode;
        int hold;
        int exp_div;
        bit exp_mode;
    } vec_t;

    vec_t table_v [10];

    clock_control #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD),
        .DIVISOR_RESET   (5'd25)
    ) dut (
        .clock_100mhz     (clock_100mhz),
        .reset            (reset),
        .key_up           (key_up),
        .key_down         (key_down),
        .key_mode         (key_mode),
        .clock_divisor    (clock_divisor),
        .slow_mode        (slow_mode),
        .settings_changed (settings_changed)
    );

    initial clock_100mhz = 1'b0;
    always #5 clock_100mhz = ~clock_100mhz;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit fires(input int age);
        return (age == 0) || ((age >= DELAY) && (((age - DELAY) % PERIOD) == 0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HIST_DEPTH; i++) m_hist[i] = 3'b000;
        m_clean     = 3'b000;
        m_age[0]    = 0;
        m_age[1]    = 0;
        m_div       = DRST;
        m_mode      = 1'b0;
        m_mode_rise = 1'b0;
        m_pend      = 1'b0;
        m_chg       = 1'b0;
    endtask

    task automatic model_edge(input bit [2:0] raw);
        bit       up_ev;
        bit       dn_ev;
        int       nd;
        bit       nm;
        bit       flip;
        bit [2:0] new_clean;
        up_ev = m_clean[0] && fires(m_age[0]);
        dn_ev = m_clean[1] && fires(m_age[1]);
        nd = m_div;
        if (up_ev && !dn_ev) nd = (m_div < 31) ? m_div + 1 : 31;
        else if (dn_ev && !up_ev) nd = (m_div > 1) ? m_div - 1 : 1;
        nm     = m_mode ^ m_mode_rise;
        m_chg  = m_pend;
        m_pend = (nd != m_div) || (nm != m_mode);
        m_div  = nd;
        m_mode = nm;
        for (int i = HIST_DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = raw;
        // samples reaching the debouncer lag the pins by two flops
        for (int k = 0; k < 3; k++) begin
            flip = 1'b1;
            for (int j = 2; j < HIST_DEPTH; j++) if (m_hist[j][k] == m_clean[k]) flip = 1'b0;
            new_clean[k] = flip ? ~m_clean[k] : m_clean[k];
        end
        for (int k = 0; k < 2; k++) begin
            if (new_clean[k] && !m_clean[k]) m_age[k] = 0;
            else if (new_clean[k]) m_age[k] = m_age[k] + 1;
        end
        m_mode_rise = new_clean[2] && !m_clean[2];
        m_clean = new_clean;
    endtask

    task automatic tick();
        @(posedge clock_100mhz);
        if (reset) model_reset();
        else model_edge({key_mode, key_down, key_up});
        @(negedge clock_100mhz);
        check("model_div", int'(clock_divisor), m_div);
        check("model_mode", int'(slow_mode), int'(m_mode));
        check("model_chg", int'(settings_changed), int'(m_chg));
        if (settings_changed) pulse_count++;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_async_div", int'(clock_divisor), DRST);
        check("rst_async_mode", int'(slow_mode), 0);
        check("rst_async_chg", int'(settings_changed), 0);
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic keys(input bit u, input bit d, input bit m);
        key_up   = u;
        key_down = d;
        key_mode = m;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulse_count = 0;
        keys(0, 0, 0);
        reset = 1'b1;
        model_reset();

        table_v[0] = '{1, 0, 0,  8, 26, 0};
        table_v[1] = '{0, 1, 0,  8, 25, 0};
        table_v[2] = '{0, 0, 1,  8, 25, 1};
        table_v[3] = '{1, 0, 0, 30, 28, 1};
        table_v[4] = '{1, 1, 0,  8, 28, 1};
        table_v[5] = '{0, 1, 0, 25, 26, 1};
        table_v[6] = '{0, 0, 1,  3, 26, 1};
        table_v[7] = '{0, 0, 1,  4, 26, 0};
        table_v[8] = '{1, 0, 0,  4, 27, 0};
        table_v[9] = '{1, 0, 1,  8, 28, 1};

        // idle after reset
        repeat (3) @(negedge clock_100mhz);
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_div", int'(clock_divisor), DRST);
            check("idle_chg", int'(settings_changed), 0);
        end
        check("idle_mode", int'(slow_mode), 0);

        // exact timing of press, hold, repeat and release
        do_reset(2);
        pulse_count = 0;
        keys(1, 0, 0);
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (c == 6)  check("t_c6_div", int'(clock_divisor), 25);
            if (c == 7)  check("t_c7_div", int'(clock_divisor), 26);
            if (c == 7)  check("t_c7_chg", int'(settings_changed), 0);
            if (c == 8)  check("t_c8_chg", int'(settings_changed), 1);
            if (c == 9)  check("t_c9_chg", int'(settings_changed), 0);
            if (c == 26) check("t_c26_div", int'(clock_divisor), 26);
            if (c == 27) check("t_c27_div", int'(clock_divisor), 27);
            if (c == 31) check("t_c31_div", int'(clock_divisor), 27);
            if (c == 32) check("t_c32_div", int'(clock_divisor), 28);
            if (c == 30) keys(0, 0, 0);
        end
        check("t_final_div", int'(clock_divisor), 28);
        check("t_pulses", pulse_count, 3);

        // bounce shorter than the debounce window
        do_reset(2);
        pulse_count = 0;
        for (int c = 0; c < 12; c++) begin
            key_up = ((c / 2) % 2) == 0;
            tick();
        end
        key_up = 1'b0;
        repeat (20) tick();
        check("bounce_div", int'(clock_divisor), 25);
        check("bounce_pulses", pulse_count, 0);

        // saturation at both ends
        do_reset(2);
        keys(1, 0, 0);
        repeat (60) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("sat_top_reach", int'(clock_divisor), 31);
        pulse_count = 0;
        keys(1, 0, 0);
        repeat (60) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("sat_top_div", int'(clock_divisor), 31);
        check("sat_top_pulses", pulse_count, 0);
        keys(0, 1, 0);
        repeat (200) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("sat_bot_reach", int'(clock_divisor), 1);
        pulse_count = 0;
        keys(0, 1, 0);
        repeat (60) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("sat_bot_div", int'(clock_divisor), 1);
        check("sat_bot_pulses", pulse_count, 0);

        // simultaneous up/down, then mode toggles
        do_reset(2);
        pulse_count = 0;
        keys(1, 1, 0);
        repeat (10) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("cancel_div", int'(clock_divisor), 25);
        check("cancel_pulses", pulse_count, 0);
        keys(0, 0, 1);
        repeat (8) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("mode_on", int'(slow_mode), 1);
        check("mode_on_pulses", pulse_count, 1);
        keys(0, 0, 1);
        repeat (8) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        check("mode_off", int'(slow_mode), 0);
        check("mode_off_pulses", pulse_count, 2);

        // reset in the middle of auto-repeat with the key still held
        do_reset(2);
        keys(0, 0, 1);
        repeat (8) tick();
        keys(0, 0, 0);
        repeat (15) tick();
        keys(1, 0, 0);
        for (int c = 1; c <= 34; c++) tick();
        check("mid_div_before", int'(clock_divisor), 28);
        check("mid_mode_before", int'(slow_mode), 1);
        do_reset(2);
        pulse_count = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 6) check("mid_c6_div", int'(clock_divisor), 25);
            if (c == 7) check("mid_c7_div", int'(clock_divisor), 26);
        end
        check("mid_pulses", pulse_count, 1);
        keys(0, 0, 0);
        repeat (15) tick();
        check("mid_final_div", int'(clock_divisor), 26);

        // table-driven vectors from a fresh reset
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            keys(table_v[i].up, table_v[i].down, table_v[i].mode);
            repeat (table_v[i].hold) tick();
            keys(0, 0, 0);
            repeat (14) tick();
            check($sformatf("vec%0d_div", i), int'(clock_divisor), table_v[i].exp_div);
            check($sformatf("vec%0d_mode", i), int'(slow_mode), int'(table_v[i].exp_mode));
        end

        // randomized runs with bounces and occasional resets
        begin
            int run [3];
            bit lvl [3];
            for (int k = 0; k < 3; k++) begin
                run[k] = 0;
                lvl[k] = 1'b0;
            end
            for (int c = 0; c < 4000; c++) begin
                for (int k = 0; k < 3; k++) begin
                    if (run[k] == 0) begin
                        lvl[k] = ~lvl[k];
                        if ($urandom_range(0, 9) < 3) run[k] = $urandom_range(1, 3);
                        else run[k] = $urandom_range(4, 60);
                    end
                    run[k]--;
                end
                keys(lvl[0], lvl[1], lvl[2]);
                if ($urandom_range(0, 799) == 0) do_reset($urandom_range(1, 3));
                else tick();
            end
            keys(0, 0, 0);
            repeat (20) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
